// File: rtl/doom58_pkg.sv
// Shared widths, spawn defaults and sequencer state encoding for the frame loop.
package doom58_pkg;

   localparam int POS_X_W   = 14;
   localparam int POS_Y_W   = 13;
   localparam int ANGLE_W   = 8;
   localparam int FRAME_W   = 16;
   localparam int OVERRUN_W = 8;
   localparam int WD_W      = 24;

   localparam logic [POS_X_W-1:0] DEF_SPAWN_X     = 14'd1600;
   localparam logic [POS_Y_W-1:0] DEF_SPAWN_Y     = 13'd1600;
   localparam logic [ANGLE_W-1:0] DEF_SPAWN_ANGLE = 8'd0;
   localparam logic [WD_W-1:0]    DEF_TIMEOUT     = 24'd1000000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_UPDATE_REQ,
      ST_UPDATE_WAIT,
      ST_COMMIT,
      ST_RENDER_REQ,
      ST_RENDER_WAIT
   } seq_state_t;

   typedef struct packed {
      logic [POS_X_W-1:0] x;
      logic [POS_Y_W-1:0] y;
      logic [ANGLE_W-1:0] angle;
   } player_state_t;

endpackage

// File: rtl/handshake_watchdog.sv
// Cycle counter guarding a start/done handshake; flags expiry on the last allowed cycle.
module handshake_watchdog #(
   parameter int               WIDTH   = 24,
   parameter logic [WIDTH-1:0] TIMEOUT = WIDTH'(1000000)
) (
   input  logic clock,
   input  logic resetn,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [WIDTH-1:0] LIMIT = TIMEOUT - WIDTH'(1);

   logic [WIDTH-1:0] count;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + WIDTH'(1);
      end
   end

   assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame game loop initiator: owns player state and sequences updater and renderer handshakes.
module frame_sequencer
   import doom58_pkg::*;
#(
   parameter logic [POS_X_W-1:0] SPAWN_X     = DEF_SPAWN_X,
   parameter logic [POS_Y_W-1:0] SPAWN_Y     = DEF_SPAWN_Y,
   parameter logic [ANGLE_W-1:0] SPAWN_ANGLE = DEF_SPAWN_ANGLE,
   parameter logic [WD_W-1:0]    TIMEOUT     = DEF_TIMEOUT
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 frame_tick,
   input  logic                 respawn,
   output logic                 update_start,
   input  logic                 update_done,
   input  logic [POS_X_W-1:0]   next_pos_x,
   input  logic [POS_Y_W-1:0]   next_pos_y,
   input  logic [ANGLE_W-1:0]   next_angle,
   output logic [POS_X_W-1:0]   cur_pos_x,
   output logic [POS_Y_W-1:0]   cur_pos_y,
   output logic [ANGLE_W-1:0]   cur_angle,
   output logic                 render_start,
   input  logic                 render_done,
   output logic                 busy,
   output logic [FRAME_W-1:0]   frame_count,
   output logic [OVERRUN_W-1:0] overrun_count,
   output logic                 timeout_err
);

   localparam player_state_t SPAWN = {SPAWN_X, SPAWN_Y, SPAWN_ANGLE};

   seq_state_t    state, next_state;
   player_state_t player;
   logic          pending;
   logic          wd_clear, wd_enable, wd_expired;
   logic          abort;
   logic          frame_start;

   assign frame_start = (state == ST_IDLE) && !respawn && (frame_tick || pending);

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      next_state = state;
      wd_clear   = 1'b0;
      wd_enable  = 1'b0;
      abort      = 1'b0;
      case (state)
         ST_IDLE:        if (frame_start) next_state = ST_UPDATE_REQ;
         ST_UPDATE_REQ: begin
            wd_clear   = 1'b1;
            next_state = ST_UPDATE_WAIT;
         end
         ST_UPDATE_WAIT: begin
            wd_enable = 1'b1;
            if (update_done) begin
               next_state = ST_COMMIT;
            end else if (wd_expired) begin
               abort      = 1'b1;
               next_state = ST_IDLE;
            end
         end
         ST_COMMIT:      next_state = ST_RENDER_REQ;
         ST_RENDER_REQ: begin
            wd_clear   = 1'b1;
            next_state = ST_RENDER_WAIT;
         end
         ST_RENDER_WAIT: begin
            wd_enable = 1'b1;
            if (render_done) begin
               next_state = ST_IDLE;
            end else if (wd_expired) begin
               abort      = 1'b1;
               next_state = ST_IDLE;
            end
         end
         default:        next_state = ST_IDLE;
      endcase
   end

   // Strobes and busy are registered from next_state so they line up with the state they describe.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state        <= ST_IDLE;
         update_start <= 1'b0;
         render_start <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= next_state;
         update_start <= (next_state == ST_UPDATE_REQ);
         render_start <= (next_state == ST_RENDER_REQ);
         busy         <= (next_state != ST_IDLE);
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         player        <= SPAWN;
         pending       <= 1'b0;
         frame_count   <= '0;
         overrun_count <= '0;
         timeout_err   <= 1'b0;
      end else begin
         if (state == ST_IDLE && respawn) begin
            player <= SPAWN;
         end else if (state == ST_COMMIT) begin
            player <= {next_pos_x, next_pos_y, next_angle};
         end

         // A tick arriving mid-frame is held once; any further ones are counted as dropped.
         if (frame_start) begin
            pending <= 1'b0;
         end else if (state != ST_IDLE && frame_tick) begin
            if (!pending) begin
               pending <= 1'b1;
            end else if (overrun_count != '1) begin
               overrun_count <= overrun_count + OVERRUN_W'(1);
            end
         end

         if (state == ST_RENDER_WAIT && render_done) begin
            frame_count <= frame_count + FRAME_W'(1);
         end

         if (abort) begin
            timeout_err <= 1'b1;
         end
      end
   end

   assign cur_pos_x = player.x;
   assign cur_pos_y = player.y;
   assign cur_angle = player.angle;

   handshake_watchdog #(
      .WIDTH   (WD_W),
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clock   (clock),
      .resetn  (resetn),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expired (wd_expired)
   );

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: directed table, multi-cycle corner sequences, random vs model.
module tb_frame_sequencer;

   localparam int T = 16;

   logic        clock = 1'b0;
   logic        resetn;
   logic        frame_tick, respawn, update_done, render_done;
   logic [13:0] next_pos_x;
   logic [12:0] next_pos_y;
   logic [7:0]  next_angle;
   logic        update_start, render_start, busy, timeout_err;
   logic [13:0] cur_pos_x;
   logic [12:0] cur_pos_y;
   logic [7:0]  cur_angle;
   logic [15:0] frame_count;
   logic [7:0]  overrun_count;

   always #5 clock = ~clock;

   frame_sequencer #(.TIMEOUT(24'd16)) dut (
      .clock         (clock),
      .resetn        (resetn),
      .frame_tick    (frame_tick),
      .respawn       (respawn),
      .update_start  (update_start),
      .update_done   (update_done),
      .next_pos_x    (next_pos_x),
      .next_pos_y    (next_pos_y),
      .next_angle    (next_angle),
      .cur_pos_x     (cur_pos_x),
      .cur_pos_y     (cur_pos_y),
      .cur_angle     (cur_angle),
      .render_start  (render_start),
      .render_done   (render_done),
      .busy          (busy),
      .frame_count   (frame_count),
      .overrun_count (overrun_count),
      .timeout_err   (timeout_err)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [62:0] pack(input logic us, input logic rs, input logic bz,
                                        input logic [15:0] fc, input logic [7:0] ov, input logic er,
                                        input logic [13:0] x, input logic [12:0] y, input logic [7:0] a);
      return {us, rs, bz, fc, ov, er, x, y, a};
   endfunction

   function automatic logic [62:0] dut_pack();
      return pack(update_start, render_start, busy, frame_count, overrun_count, timeout_err,
                  cur_pos_x, cur_pos_y, cur_angle);
   endfunction

   // Reference model: frame phase, cycles spent waiting, and the spec's bookkeeping counters.
   localparam int P_IDLE = 0, P_UREQ = 1, P_UWAIT = 2, P_COMMIT = 3, P_RREQ = 4, P_RWAIT = 5;
   int          m_phase, m_waited;
   bit          m_pend, m_err;
   logic [15:0] m_fc;
   int          m_ov;
   logic [13:0] m_x;
   logic [12:0] m_y;
   logic [7:0]  m_a;

   task automatic model_reset();
      m_phase = P_IDLE; m_waited = 0; m_pend = 0; m_err = 0;
      m_fc = 16'd0; m_ov = 0; m_x = 14'd1600; m_y = 13'd1600; m_a = 8'd0;
   endtask

   function automatic logic [62:0] model_pack();
      return pack(m_phase == P_UREQ, m_phase == P_RREQ, m_phase != P_IDLE, m_fc, 8'(m_ov), m_err,
                  m_x, m_y, m_a);
   endfunction

   task automatic model_step();
      if (m_phase != P_IDLE && frame_tick) begin
         if (!m_pend) m_pend = 1;
         else if (m_ov < 255) m_ov++;
      end
      case (m_phase)
         P_IDLE: begin
            if (respawn) begin
               m_x = 14'd1600; m_y = 13'd1600; m_a = 8'd0;
            end else if (frame_tick || m_pend) begin
               m_pend = 0; m_phase = P_UREQ;
            end
         end
         P_UREQ: begin m_phase = P_UWAIT; m_waited = 0; end
         P_UWAIT: begin
            if (update_done) m_phase = P_COMMIT;
            else if (m_waited == T - 1) begin m_phase = P_IDLE; m_err = 1; end
            else m_waited++;
         end
         P_COMMIT: begin
            m_x = next_pos_x; m_y = next_pos_y; m_a = next_angle; m_phase = P_RREQ;
         end
         P_RREQ: begin m_phase = P_RWAIT; m_waited = 0; end
         default: begin
            if (render_done) begin m_fc = m_fc + 16'd1; m_phase = P_IDLE; end
            else if (m_waited == T - 1) begin m_phase = P_IDLE; m_err = 1; end
            else m_waited++;
         end
      endcase
   endtask

   // Inputs are applied at a falling edge; the model advances over the following rising edge.
   task automatic drive(input bit tk, input bit rs, input bit ud, input bit rd);
      frame_tick = tk; respawn = rs; update_done = ud; render_done = rd;
      model_step();
      @(negedge clock);
   endtask

   task automatic step(input bit tk, input bit rs, input bit ud, input bit rd);
      drive(tk, rs, ud, rd);
      check("model", dut_pack(), model_pack());
   endtask

   // Called right after update_start is observed; completes the frame with the given gaps.
   task automatic frame_after_start(input int ugap, input int rgap);
      repeat (ugap) step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      repeat (rgap) step(0, 0, 0, 0);
      step(0, 0, 0, 1);
   endtask

   typedef struct {
      bit          tk, ud, rd;
      bit          us, rs, bz;
      logic [15:0] fc;
      bit          committed;
   } vec_t;

   function automatic vec_t mk(input bit tk, input bit ud, input bit rd, input bit us, input bit rs,
                               input bit bz, input logic [15:0] fc, input bit committed);
      vec_t v;
      v.tk = tk; v.ud = ud; v.rd = rd; v.us = us; v.rs = rs; v.bz = bz; v.fc = fc;
      v.committed = committed;
      return v;
   endfunction

   localparam logic [62:0] RESET_PACK = {3'b000, 16'd0, 8'd0, 1'b0, 14'd1600, 13'd1600, 8'd0};

   vec_t tbl[18];
   int   n;

   initial begin
      resetn = 1'b0;
      frame_tick = 0; respawn = 0; update_done = 0; render_done = 0;
      next_pos_x = '0; next_pos_y = '0; next_angle = '0;
      model_reset();
      repeat (2) @(negedge clock);
      check("reset_state", dut_pack(), RESET_PACK);
      resetn = 1'b1;

      // Nominal frame: done 3 cycles after update_start, render_done 10 after render_start.
      tbl[0]  = mk(1, 0, 0, 1, 0, 1, 16'd0, 0);
      tbl[1]  = mk(0, 0, 0, 0, 0, 1, 16'd0, 0);
      tbl[2]  = mk(0, 0, 1, 0, 0, 1, 16'd0, 0);
      tbl[3]  = mk(0, 0, 0, 0, 0, 1, 16'd0, 0);
      tbl[4]  = mk(0, 1, 0, 0, 0, 1, 16'd0, 0);
      tbl[5]  = mk(0, 0, 0, 0, 1, 1, 16'd0, 1);
      for (int i = 6; i < 16; i++) tbl[i] = mk(0, 0, 0, 0, 0, 1, 16'd0, 1);
      tbl[16] = mk(0, 0, 1, 0, 0, 0, 16'd1, 1);
      tbl[17] = mk(0, 1, 0, 0, 0, 0, 16'd1, 1);
      next_pos_x = 14'd1610; next_pos_y = 13'd1595; next_angle = 8'd5;
      for (int i = 0; i < 18; i++) begin
         drive(tbl[i].tk, 0, tbl[i].ud, tbl[i].rd);
         check($sformatf("nominal_row%0d", i), dut_pack(),
               pack(tbl[i].us, tbl[i].rs, tbl[i].bz, tbl[i].fc, 8'd0, 1'b0,
                    tbl[i].committed ? 14'd1610 : 14'd1600,
                    tbl[i].committed ? 13'd1595 : 13'd1600,
                    tbl[i].committed ? 8'd5 : 8'd0));
      end

      // Overrun: three ticks in UPDATE_WAIT, then the pending tick starts the next frame.
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      repeat (3) step(1, 0, 0, 0);
      check("overrun_two", overrun_count, 8'd2);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      repeat (2) step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      check("overrun_idle_after_frame", {busy, frame_count}, {1'b0, 16'd2});
      step(0, 0, 0, 0);
      check("pending_starts_frame", update_start, 1'b1);
      frame_after_start(1, 1);

      // Respawn beats a simultaneous tick, and the tick is not remembered.
      next_pos_x = 14'd2000; next_pos_y = 13'd900; next_angle = 8'd40;
      step(1, 0, 0, 0);
      frame_after_start(1, 1);
      check("pre_respawn_cur", {cur_pos_x, cur_pos_y, cur_angle}, {14'd2000, 13'd900, 8'd40});
      step(1, 1, 0, 0);
      check("respawn_cur", {cur_pos_x, cur_pos_y, cur_angle}, {14'd1600, 13'd1600, 8'd0});
      check("respawn_no_start", {update_start, busy}, 2'b00);
      repeat (3) step(0, 0, 0, 0);
      check("respawn_tick_dropped", busy, 1'b0);

      // Randomized traffic against the model.
      for (int i = 0; i < 2000; i++) begin
         next_pos_x = 14'($urandom); next_pos_y = 13'($urandom); next_angle = 8'($urandom);
         step($urandom_range(0, 9) == 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      end
      n = 0;
      while ((m_phase != P_IDLE || m_pend) && n < 100) begin
         step(0, 0, 0, 0);
         n++;
      end
      check("drain_to_idle", busy, 1'b0);

      // Asynchronous reset in the middle of RENDER_WAIT.
      next_pos_x = 14'd3000; next_pos_y = 13'd100; next_angle = 8'd77;
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      check("in_render_wait", {busy, render_start, cur_pos_x}, {1'b1, 1'b0, 14'd3000});
      #2 resetn = 1'b0;
      #1 check("async_reset", dut_pack(), RESET_PACK);
      model_reset();
      @(negedge clock);
      resetn = 1'b1;

      // Watchdog: update_done never arrives.
      next_pos_x = 14'd1234; next_pos_y = 13'd567; next_angle = 8'd89;
      step(1, 0, 0, 0);
      n = 0;
      while (busy && n < 40) begin
         step(0, 0, 0, 0);
         n++;
      end
      check("timeout_len", n, 17);
      check("timeout_err", timeout_err, 1'b1);
      check("timeout_cur_kept", {cur_pos_x, cur_pos_y, cur_angle}, {14'd1600, 13'd1600, 8'd0});
      check("timeout_fc_kept", frame_count, 16'd0);

      // Frame counter wrap from a preloaded 16'hFFFF.
      force dut.frame_count = 16'hFFFF;
      #1 release dut.frame_count;
      m_fc = 16'hFFFF;
      check("fc_preload", frame_count, 16'hFFFF);
      step(1, 0, 0, 0);
      frame_after_start(1, 1);
      check("fc_wrap", frame_count, 16'd0);

      // Overrun saturation under a tick every cycle.
      repeat (400) step(1, 0, 0, 0);
      check("overrun_sat", overrun_count, 8'hFF);
      repeat (20) step(1, 0, 0, 0);
      check("overrun_held", overrun_count, 8'hFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
